elink_tx_serializer: RTL and testbench
======================================

# elink_tx_serializer

Downstream consumer of the TX e-link FIFO. It pulls 10-bit words `{delimeter[1:0], data[7:0]}` from the FIFO with a single-cycle read-request handshake and serializes them MSB-first onto the e-link, W bits per clock. It inserts a fixed comma/idle symbol whenever no word is ready, and it tracks frame state from the delimiter field. It sits between `fifo_TXelink_wrap` and the e-link output pads, in the FIFO read-clock domain.

## Interface

Parameters:

- `ELINK_WIDTH`, 2: bits per clock on `edata_out`. Legal values are 1 and 2.
- `WORD_WIDTH`, 10: symbol width. Fixed at 10.
- `IDLE_SYMBOL`, 10'b0011111010: K28.5 (RD−) pattern sent when no word is ready.

Ports (one clock; reset is asynchronous and active-low):

- `clk`  in  1: serializer clock, equal to the FIFO `rd_clk`.
- `rst`  in  1: asynchronous, active-low reset.
- `dout_efifo`  in  10: FIFO read data `{delimeter, data}`.
- `dout_rdy_efifo`  in  1: FIFO read data valid.
- `empty_efifo`  in  1: FIFO empty.
- `rd_en`  out  1: one-cycle read request to the FIFO.
- `edata_out`  out  ELINK_WIDTH: serial e-link data, MSB first.
- `sym_strobe`  out  1: pulses on the cycle a new symbol starts shifting.
- `in_frame`  out  1: high between SOP and EOP.
- `underrun`  out  1: one-cycle pulse when idle is inserted while `in_frame`.
- `proto_err`  out  1: sticky delimiter-protocol error.

## Operation

- N = WORD_WIDTH/ELINK_WIDTH, i.e. 5 or 10. `bit_cnt` counts 0..N-1 and wraps, free-running after reset.
- `shift_reg[9:0]` drives `edata_out` from its top ELINK_WIDTH bits and shifts left by ELINK_WIDTH each cycle.
- **Prefetch:** at `bit_cnt == N-3`, if `!empty_efifo`, `!nxt_valid` and `!req_pending`:
  - assert `rd_en` for exactly one cycle;
  - set `req_pending`.
- **Capture:** on `dout_rdy_efifo`:
  - `nxt_word <= dout_efifo`, `nxt_valid <= 1`, `req_pending <= 0`;
  - this is accepted in any cycle, including late arrivals.
- **Load:** at `bit_cnt == N-1`:
  - if `nxt_valid`: `shift_reg <= nxt_word` and `nxt_valid <= 0`;
  - otherwise: `shift_reg <= IDLE_SYMBOL`.
  - `sym_strobe` is high the following cycle, aligned with the first bits of the new symbol.
- **Simultaneous capture and load on the same cycle:** the load uses the old `nxt_valid`, so idle is sent, and the captured word is held for the next symbol. No word is ever dropped.
- **Frame FSM**, states IDLE and FRAME, evaluated on each data-word load (delimiter 10 = SOP, 01 = EOP, 00 = data, 11 = reserved):
  - IDLE + SOP → FRAME.
  - FRAME + EOP → IDLE.
  - IDLE + data/EOP → `proto_err`, stay IDLE.
  - FRAME + SOP → `proto_err`, stay FRAME.
  - Reserved in any state → `proto_err`, state unchanged.
- **Underrun:** an idle load while in FRAME pulses `underrun`; the state stays FRAME.
- `in_frame` is high when the state is FRAME.
- `proto_err` clears only on reset.

## Timing

- Reset values:
  - `rd_en` = 0, `sym_strobe` = 0, `underrun` = 0, `in_frame` = 0, `proto_err` = 0;
  - `shift_reg` = IDLE_SYMBOL, so `edata_out` = its MSBs (2'b00 for W=2);
  - `bit_cnt` = 0, `nxt_valid` = 0, `req_pending` = 0.
- The first load occurs at cycle N-1 after reset release.
- FIFO latency: `dout_rdy_efifo` is expected one cycle after `rd_en`. With the prefetch at N-3, the word is captured by N-2 and loaded at N-1.
- Back-to-back words from a non-empty FIFO give a continuous stream with no idles: one word per N cycles, which is 80% line efficiency in data bits.
- Symbol boundary: the first ELINK_WIDTH bits of the loaded symbol appear on `edata_out` the cycle after the load, coincident with `sym_strobe`.
- Reset asserted mid-symbol:
  - all state clears asynchronously;
  - a pending read is abandoned, and a `dout_rdy_efifo` arriving after release is still captured.
- Every output is registered; there is no combinational path from input to output.

## Test plan

- **Reset and idle:** FIFO empty for 50 cycles → `edata_out` repeats 0011111010 every N cycles, `rd_en` stays 0, `sym_strobe` pulses every N cycles, `proto_err` = 0.
- **Single frame:** words 0x2A5, 0x033, 0x1C7 (SOP, data, EOP) preloaded, W=2 → `rd_en` once per symbol, serial stream equals the words MSB-first with no idles, `in_frame` high over exactly 3 symbols, then idle.
- **Underrun:** SOP word, then FIFO empty for 2 symbols, then EOP word → 2 idle symbols, `underrun` pulses twice, `in_frame` stays high until the EOP load.
- **Late data:** `dout_rdy_efifo` delayed to coincide with the load cycle → idle sent, and the word is sent in the next symbol, unaltered.
- **Protocol errors:** data word while IDLE → `proto_err` = 1 and sticky; SOP, SOP → error, `in_frame` = 1; delimiter 11 → error.
- **Reset mid-symbol (W=1):** assert `rst` = 0 at `bit_cnt` = 4 of a data symbol → all outputs at reset values within the same cycle, stream restarts with idle at cycle 9 after release.

Source files
------------

// File: rtl/elink_tx_serializer.sv
// ---------------------------------------------------------------------------
// elink_tx_serializer
//
// Pulls 10-bit words {delimiter[1:0], data[7:0]} from the TX e-link FIFO with
// a single-cycle read request, and shifts them MSB-first onto the e-link,
// ELINK_WIDTH bits per clock. When no word is ready at a symbol boundary the
// fixed comma/idle symbol is sent instead. The delimiter field of every data
// word drives a small frame tracker (IDLE/FRAME) that flags protocol errors
// and underruns.
//
// Ports
//   clk             serializer clock (FIFO read clock)
//   rst             asynchronous, active-low reset
//   dout_efifo      FIFO read data {delimiter, data}
//   dout_rdy_efifo  FIFO read data valid
//   empty_efifo     FIFO empty
//   rd_en           one-cycle read request to the FIFO
//   edata_out       serial e-link data, MSB first
//   sym_strobe      high on the cycle a new symbol starts shifting out
//   in_frame        high between SOP and EOP
//   underrun        one-cycle pulse when idle is inserted inside a frame
//   proto_err       sticky delimiter-protocol error, cleared only by reset
//
// Frame tracker states
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | outside a frame; only SOP is a legal delimiter
//   ST_FRAME | between SOP and EOP; data or EOP expected, idle = underrun
// ---------------------------------------------------------------------------
module elink_tx_serializer #(
  parameter int                    ELINK_WIDTH = 2,
  parameter int                    WORD_WIDTH  = 10,
  parameter logic [WORD_WIDTH-1:0] IDLE_SYMBOL = 10'b0011111010
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_WIDTH-1:0]  dout_efifo,
  input  logic                   dout_rdy_efifo,
  input  logic                   empty_efifo,
  output logic                   rd_en,
  output logic [ELINK_WIDTH-1:0] edata_out,
  output logic                   sym_strobe,
  output logic                   in_frame,
  output logic                   underrun,
  output logic                   proto_err
);

  localparam int N     = WORD_WIDTH / ELINK_WIDTH;
  localparam int CNT_W = $clog2(N);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  // rd_en is registered, so the decision is taken one count early; the
  // request is then visible to the FIFO during count N-3, data returns
  // during N-2 and is ready for the load at N-1.
  localparam logic [CNT_W-1:0] CNT_REQ  = CNT_W'(N - 4);

  localparam logic [1:0] DLM_DATA = 2'b00;
  localparam logic [1:0] DLM_EOP  = 2'b01;
  localparam logic [1:0] DLM_SOP  = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_e;

  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [WORD_WIDTH-1:0] nxt_word_q, nxt_word_d;
  logic                  nxt_valid_q, nxt_valid_d;
  logic                  req_pending_q, req_pending_d;
  logic                  rd_en_q, rd_en_d;
  logic                  sym_strobe_q, sym_strobe_d;
  logic                  underrun_q, underrun_d;
  logic                  proto_err_q, proto_err_d;
  frame_state_e          state_q, state_d;

  logic                  load;
  logic                  load_word;
  logic                  load_idle;
  logic                  capture;
  logic                  issue;
  logic [1:0]            dlm;

  assign load      = (bit_cnt_q == CNT_LAST);
  // The load looks at the registered nxt_valid only, so a word captured on
  // the load cycle itself waits for the next symbol instead of being lost.
  assign load_word = load & nxt_valid_q;
  assign load_idle = load & ~nxt_valid_q;
  assign capture   = dout_rdy_efifo;
  assign issue     = (bit_cnt_q == CNT_REQ) & ~empty_efifo & ~nxt_valid_q
                     & ~req_pending_q;
  assign dlm       = nxt_word_q[WORD_WIDTH-1 -: 2];

  // -------------------------------------------------------------------------
  // Datapath: symbol counter, shifter, one-word prefetch buffer, FIFO request
  // -------------------------------------------------------------------------
  always_comb begin
    bit_cnt_d     = load ? '0 : bit_cnt_q + CNT_W'(1);
    shift_d       = shift_q << ELINK_WIDTH;
    nxt_word_d    = nxt_word_q;
    nxt_valid_d   = nxt_valid_q;
    req_pending_d = req_pending_q;
    rd_en_d       = issue;
    sym_strobe_d  = load;

    if (load) begin
      shift_d = nxt_valid_q ? nxt_word_q : IDLE_SYMBOL;
      if (nxt_valid_q) begin
        nxt_valid_d = 1'b0;
      end
    end

    // Capture after the load so a same-cycle arrival survives the clear.
    if (capture) begin
      nxt_word_d    = dout_efifo;
      nxt_valid_d   = 1'b1;
      req_pending_d = 1'b0;
    end

    if (issue) begin
      req_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q     <= '0;
      shift_q       <= IDLE_SYMBOL;
      nxt_word_q    <= '0;
      nxt_valid_q   <= 1'b0;
      req_pending_q <= 1'b0;
      rd_en_q       <= 1'b0;
      sym_strobe_q  <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      nxt_word_q    <= nxt_word_d;
      nxt_valid_q   <= nxt_valid_d;
      req_pending_q <= req_pending_d;
      rd_en_q       <= rd_en_d;
      sym_strobe_q  <= sym_strobe_d;
    end
  end

  // -------------------------------------------------------------------------
  // Frame tracker
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    proto_err_d = proto_err_q;
    underrun_d  = 1'b0;

    if (load_word) begin
      case (dlm)
        DLM_SOP: begin
          if (state_q == ST_FRAME) begin
            proto_err_d = 1'b1;
          end else begin
            state_d = ST_FRAME;
          end
        end
        DLM_EOP: begin
          if (state_q == ST_FRAME) begin
            state_d = ST_IDLE;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        DLM_DATA: begin
          if (state_q == ST_IDLE) begin
            proto_err_d = 1'b1;
          end
        end
        default: begin
          proto_err_d = 1'b1;
        end
      endcase
    end else if (load_idle && (state_q == ST_FRAME)) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      proto_err_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
      underrun_q  <= underrun_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign edata_out  = shift_q[WORD_WIDTH-1 -: ELINK_WIDTH];
  assign sym_strobe = sym_strobe_q;
  assign in_frame   = (state_q == ST_FRAME);
  assign underrun   = underrun_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_elink_tx_serializer.sv
module tb_elink_tx_serializer;

  localparam int         W    = 2;
  localparam int         N    = 10 / W;
  localparam logic [9:0] IDLE = 10'b0011111010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (W=2)
  logic       rst;
  logic [9:0] dout_m;
  logic       rdy_m;
  logic       empty_m;
  logic       rd_en;
  logic [1:0] edata;
  logic       strobe, inf, und, perr;

  // second instance (W=1) for the mid-symbol reset scenario
  logic       rst1;
  logic [9:0] dout1;
  logic       rdy1;
  logic       empty1;
  logic       rd_en1;
  logic [0:0] edata1;
  logic       strobe1, inf1, und1, perr1;

  elink_tx_serializer #(.ELINK_WIDTH(2)) u_dut (
    .clk(clk), .rst(rst), .dout_efifo(dout_m), .dout_rdy_efifo(rdy_m),
    .empty_efifo(empty_m), .rd_en(rd_en), .edata_out(edata),
    .sym_strobe(strobe), .in_frame(inf), .underrun(und), .proto_err(perr));

  elink_tx_serializer #(.ELINK_WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .dout_efifo(dout1), .dout_rdy_efifo(rdy1),
    .empty_efifo(empty1), .rd_en(rd_en1), .edata_out(edata1),
    .sym_strobe(strobe1), .in_frame(inf1), .underrun(und1), .proto_err(perr1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- FIFO model + responder (main instance) ----------------
  logic [9:0] fq[$];
  logic [9:0] exp_q[$];
  int         lat = 1;
  int         pend_cnt = 0;
  logic [9:0] pend_w;
  logic       prev_rd = 1'b0;
  int         rd_cnt = 0;

  task automatic push(input logic [9:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  initial begin
    dout_m  = '0;
    rdy_m   = 1'b0;
    empty_m = 1'b1;
  end

  always @(negedge clk) begin
    rdy_m = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        dout_m = pend_w;
        rdy_m  = 1'b1;
      end
    end
    if (rst && rd_en) begin
      rd_cnt++;
      check("rd_pulse_width", prev_rd, 0);
      check("rd_overlap", pend_cnt, 0);
      if (fq.size() == 0) begin
        check("rd_while_empty", rd_en, 0);
      end else begin
        pend_w   = fq.pop_front();
        pend_cnt = lat;
      end
    end
    prev_rd = rd_en;
    empty_m = (fq.size() == 0);
  end

  // ---------------- stream monitor + frame reference model ----------------
  int         cyc = -1;
  int         nb = 0;
  logic [9:0] sh;
  logic       snap_inf, snap_und, snap_perr;
  bit         snap_real;
  bit         model_frame = 1'b0;
  bit         model_perr  = 1'b0;
  logic [9:0] sym_log[$];
  int         und_cnt = 0;

  task automatic process_symbol(input logic [9:0] s);
    logic [9:0] w;
    bit         exp_und;
    exp_und = 1'b0;
    if (!snap_real) begin
      check("reset_symbol", s, IDLE);
    end else begin
      sym_log.push_back(s);
      if (s == IDLE) begin
        exp_und = model_frame;
      end else begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", s, IDLE);
          w = s;
        end else begin
          w = exp_q.pop_front();
          check("word", s, w);
        end
        case (w[9:8])
          2'b10:   if (model_frame) model_perr = 1'b1; else model_frame = 1'b1;
          2'b01:   if (model_frame) model_frame = 1'b0; else model_perr = 1'b1;
          2'b00:   if (!model_frame) model_perr = 1'b1;
          default: model_perr = 1'b1;
        endcase
      end
      check("in_frame", snap_inf, model_frame);
      check("underrun", snap_und, exp_und);
      check("proto_err", snap_perr, model_perr);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc = -1;
      nb  = 0;
    end else begin
      cyc++;
      check("sym_strobe", strobe, (cyc >= N) && (cyc % N == 0));
      if (und) und_cnt++;
      if (cyc % N == 0) begin
        sh        = {8'h00, edata};
        nb        = 1;
        snap_inf  = inf;
        snap_und  = und;
        snap_perr = perr;
        snap_real = (cyc >= N);
      end else begin
        check("underrun_off_boundary", und, 0);
        if (nb > 0 && nb < N) begin
          sh = {sh[7:0], edata};
          nb++;
        end
      end
      if (nb == N) begin
        process_symbol(sh);
        nb = 0;
      end
    end
  end

  function automatic logic [9:0] log_at(input int i);
    if (i < sym_log.size()) return sym_log[i];
    return 10'h3FF;
  endfunction

  function automatic int first_word(input int i0);
    int f = i0;
    while (f < sym_log.size() && sym_log[f] == IDLE) f++;
    return f;
  endfunction

  function automatic logic [9:0] rand_word();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    if (w == IDLE) w = 10'h0FB;
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int         i0, f, n, rd0, und0;
    bit         reached;
    logic [9:0] w1, idle_v;

    idle_v = IDLE;
    rst    = 1'b0;
    rst1   = 1'b0;
    dout1  = '0;
    rdy1   = 1'b0;
    empty1 = 1'b1;

    // reset values
    step(3);
    check("rst_rd_en", rd_en, 0);
    check("rst_sym_strobe", strobe, 0);
    check("rst_underrun", und, 0);
    check("rst_in_frame", inf, 0);
    check("rst_proto_err", perr, 0);
    check("rst_edata", edata, 2'b00);
    rst = 1'b1;

    // idle stream, FIFO empty for 50 cycles
    step(50);
    check("idle_rd_cnt", rd_cnt, 0);
    check("idle_sym_count", sym_log.size(), 9);
    n = 0;
    foreach (sym_log[i]) if (sym_log[i] == IDLE) n++;
    check("idle_all_idle", n, 9);
    check("idle_proto_err", perr, 0);

    // single frame, preloaded, back-to-back
    i0  = sym_log.size();
    rd0 = rd_cnt;
    push(10'h2A5);
    push(10'h033);
    push(10'h1C7);
    step(35);
    f = first_word(i0);
    check("frame_w0", log_at(f), 10'h2A5);
    check("frame_w1", log_at(f + 1), 10'h033);
    check("frame_w2", log_at(f + 2), 10'h1C7);
    check("frame_then_idle", log_at(f + 3), IDLE);
    check("frame_rd_cnt", rd_cnt - rd0, 3);
    check("frame_in_frame_end", inf, 0);

    // underrun: SOP, two empty symbols, EOP
    i0   = sym_log.size();
    und0 = und_cnt;
    push(10'h2F0);
    reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (und_cnt - und0 >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    check("underrun_wait", reached, 1);
    push(10'h10F);
    step(30);
    f = first_word(i0);
    check("ur_sop", log_at(f), 10'h2F0);
    check("ur_idle1", log_at(f + 1), IDLE);
    check("ur_idle2", log_at(f + 2), IDLE);
    check("ur_eop", log_at(f + 3), 10'h10F);
    check("ur_pulses", und_cnt - und0, 2);
    check("ur_in_frame_end", inf, 0);
    check("ur_proto_err", perr, 0);

    // late data: FIFO answers on the load cycle
    lat  = 2;
    i0   = sym_log.size();
    und0 = und_cnt;
    push(10'h2C3);
    push(10'h1E1);
    step(40);
    lat = 1;
    f = first_word(i0);
    check("late_sop", log_at(f), 10'h2C3);
    check("late_idle", log_at(f + 1), IDLE);
    check("late_eop", log_at(f + 2), 10'h1E1);
    check("late_underrun", und_cnt - und0, 1);

    // protocol errors
    check("pe_clean", perr, 0);
    push(10'h055);
    step(15);
    check("pe_data_in_idle", perr, 1);
    check("pe_data_stays_idle", inf, 0);
    push(10'h2AA);
    push(10'h280);
    step(20);
    check("pe_sop_sop_in_frame", inf, 1);
    check("pe_sticky", perr, 1);
    push(10'h101);
    step(15);
    check("pe_eop_closes", inf, 0);
    push(10'h3AA);
    step(15);
    check("pe_reserved", perr, 1);
    check("pe_reserved_state", inf, 0);

    // randomized traffic against the reference model
    for (int it = 0; it < 120; it++) begin
      lat = $urandom_range(1, 2);
      n   = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) push(rand_word());
      step($urandom_range(0, 12));
    end
    lat = 1;
    reached = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (exp_q.size() == 0 && fq.size() == 0) begin
        reached = 1'b1;
        break;
      end
      step(1);
    end
    check("drain_wait", reached, 1);
    step(15);
    check("drain_left", exp_q.size(), 0);

    // W=1: reset at bit 4 of a word symbol
    w1   = 10'h2B4;
    rst1 = 1'b1;
    empty1 = 1'b0;
    reached = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (rd_en1) begin
        reached = 1'b1;
        n = k;
        break;
      end
    end
    check("w1_rd_seen", reached, 1);
    check("w1_rd_cycle", n, 7);
    empty1 = 1'b1;
    step(1);
    dout1 = w1;
    rdy1  = 1'b1;
    step(1);
    rdy1  = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("w1_word_bit", edata1, w1[9-i]);
      if (i == 0) begin
        check("w1_strobe_first", strobe1, 1);
        check("w1_in_frame", inf1, 1);
      end
      if (i < 4) step(1);
    end
    #1 rst1 = 1'b0;
    #1;
    check("w1_rst_rd_en", rd_en1, 0);
    check("w1_rst_strobe", strobe1, 0);
    check("w1_rst_underrun", und1, 0);
    check("w1_rst_in_frame", inf1, 0);
    check("w1_rst_proto_err", perr1, 0);
    check("w1_rst_edata", edata1, 0);
    step(1);
    rst1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("w1_restart_strobe", strobe1, c == 10);
      check("w1_restart_idle_bit", edata1, idle_v[9 - (c % 10)]);
      step(1);
    end

    // W=1: reset while a read is outstanding; late data still captured
    w1 = 10'h2E7;
    empty1 = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (rd_en1) begin
        reached = 1'b1;
        break;
      end
    end
    check("w1_rd2_seen", reached, 1);
    empty1 = 1'b1;
    #1 rst1 = 1'b0;
    step(1);
    rst1  = 1'b1;
    dout1 = w1;
    rdy1  = 1'b1;
    step(1);
    rdy1  = 1'b0;
    for (int c = 1; c < 20; c++) begin
      check("w1_post_strobe", strobe1, c == 10);
      if (c >= 10) check("w1_post_word_bit", edata1, w1[19 - c]);
      if (c == 10) check("w1_post_in_frame", inf1, 1);
      step(1);
    end
    check("w1_post_proto_err", perr1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
